muldiv_ctrl: RTL and testbench

Sequencer for the RV32M multiply/divide operations that the decoder flags as multi-clock. It sits beside the ALU in the execute stage. It accepts one M-extension operation per `start`, runs a single-cycle multiply or a 32-step iterative divide, and holds the pipeline with `stall` until the result is ready. It returns the 32-bit result with a one-cycle `done` pulse.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_ctrl_div.sv | 70 +++++++
 rtl/muldiv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared ALU operation codes, sequencer state encodings and decode helpers
// used by the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [5:0] ALU_MUL    = 6'h20;
  localparam logic [5:0] ALU_MULH   = 6'h21;
  localparam logic [5:0] ALU_MULHSU = 6'h22;
  localparam logic [5:0] ALU_MULHU  = 6'h23;
  localparam logic [5:0] ALU_DIV    = 6'h24;
  localparam logic [5:0] ALU_DIVU   = 6'h25;
  localparam logic [5:0] ALU_REM    = 6'h26;
  localparam logic [5:0] ALU_REMU   = 6'h27;

  localparam int MDU_DIV_STEPS = 32;
  localparam int MDU_CNT_W     = $clog2(MDU_DIV_STEPS);

  typedef enum logic [2:0] {
    MDU_IDLE,
    MDU_MUL,
    MDU_DIV,
    MDU_FIX,
    MDU_DONE
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [5:0] code);
    return code inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_div_op(input logic [5:0] code);
    return code inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_div(input logic [5:0] code);
    return code inside {ALU_DIV, ALU_REM};
  endfunction

  function automatic logic is_rem_op(input logic [5:0] code);
    return code inside {ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div.sv
// Restoring radix-2 unsigned divider: one quotient bit per step, MSB first.
// The dividend shifts out of the quotient register as quotient bits shift in.
module div_radix2
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r,
  output logic            last
);

  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]        shifted;
  logic [XLEN:0]        diff;

  // Partial remainder is always below the divisor, so the shifted value fits XLEN+1 bits.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign q    = quo_q;
  assign r    = rem_q;
  assign last = (cnt_q == MDU_CNT_W'(MDU_DIV_STEPS - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: single-cycle multiply, 32-step divide,
// pipeline stall generation and a registered result with a one-cycle done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// MDU_IDLE | waiting for start
// MDU_MUL  | latched operands feed the multiplier; result taken next edge
// MDU_DIV  | one restoring divide iteration per edge, 32 in total
// MDU_FIX  | apply quotient/remainder signs and select the output
// MDU_DONE | result valid, done high; a new start may be accepted here
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      alucode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state_q, state_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [5:0]      code_q, code_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            idle_or_done;
  logic            accept;
  logic            sgn_in, dvd_neg, dvs_neg, rem_in;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] dvd_abs, dvs_abs, special_res;
  logic            div_load, div_step, div_last;
  logic [XLEN-1:0] div_q, div_r, q_fix, r_fix;

  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] prod;

  assign idle_or_done = (state_q == MDU_IDLE) || (state_q == MDU_DONE);
  assign accept       = start && !flush && idle_or_done;

  assign sgn_in      = is_signed_div(alucode);
  assign rem_in      = is_rem_op(alucode);
  assign dvd_neg     = sgn_in && op1[XLEN-1];
  assign dvs_neg     = sgn_in && op2[XLEN-1];
  assign dvd_abs     = dvd_neg ? -op1 : op1;
  assign dvs_abs     = dvs_neg ? -op2 : op2;
  assign div_zero    = (op2 == '0);
  assign div_ovf     = sgn_in && (op1 == INT_MIN) && (&op2);
  assign special_res = div_zero ? (rem_in ? op1 : '1) : (rem_in ? '0 : INT_MIN);

  // Low 2*XLEN bits of the 33x33 signed product are exact for every variant.
  assign mul_a = {(code_q != ALU_MULHU) && op1_q[XLEN-1], op1_q};
  assign mul_b = {((code_q == ALU_MUL) || (code_q == ALU_MULH)) && op2_q[XLEN-1], op2_q};
  assign prod  = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);

  assign q_fix = q_neg_q ? -div_q : div_q;
  assign r_fix = r_neg_q ? -div_r : div_r;

  div_radix2 #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (dvd_abs),
    .divisor  (dvs_abs),
    .q        (div_q),
    .r        (div_r),
    .last     (div_last)
  );

  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    code_d   = code_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    div_load = 1'b0;
    div_step = 1'b0;

    unique case (state_q)
      MDU_MUL: begin
        state_d  = MDU_DONE;
        result_d = (code_q == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
      MDU_DIV: begin
        div_step = 1'b1;
        if (div_last) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        state_d  = MDU_DONE;
        result_d = is_rem_op(code_q) ? r_fix : q_fix;
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = state_q;
    endcase

    if (accept) begin
      op1_d   = op1;
      op2_d   = op2;
      code_d  = alucode;
      q_neg_d = dvd_neg ^ dvs_neg;
      r_neg_d = dvd_neg;
      if (is_mul_op(alucode)) begin
        state_d = MDU_MUL;
      end else if (is_div_op(alucode)) begin
        if (div_zero || div_ovf) begin
          state_d  = MDU_DONE;
          result_d = special_res;
        end else begin
          state_d  = MDU_DIV;
          div_load = 1'b1;
        end
      end else begin
        state_d  = MDU_DONE;
        result_d = '0;
      end
    end

    // An abort leaves the last delivered result in place.
    if (flush) begin
      state_d  = MDU_IDLE;
      result_d = result_q;
      div_step = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      code_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      code_q   <= code_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == MDU_MUL) || (state_q == MDU_DIV) || (state_q == MDU_FIX);
  assign done   = (state_q == MDU_DONE);
  assign stall  = (start && !flush && idle_or_done) || busy;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, stall, result values, back-to-back,
// flush and asynchronous reset, with hand-computed expectations.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  alucode = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        stall, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int lat, gap;
  bit seen, saw_done;

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .alucode (alucode),
    .op1     (op1),
    .op2     (op2),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op, hold start while stalled, and check latency, stall and result.
  task automatic run_op(input string tag, input logic [5:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int  n;
    int  stall_cnt;
    bit  got;
    @(negedge clk);
    start = 1'b1; alucode = code; op1 = a; op2 = b;
    #1;
    stall_cnt = (stall === 1'b1) ? 1 : 0;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) begin
        got = 1'b1;
        start = 1'b0;
        #1;
        chk({tag, "_stall_in_done"}, stall, 0);
        chk({tag, "_busy_in_done"}, busy, 0);
      end else if (stall === 1'b1) begin
        stall_cnt++;
      end
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_stall_cycles"}, stall_cnt, exp_lat);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    #11 rst_n = 1'b1;

    run_op("mul",    ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
    run_op("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    run_op("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    run_op("mulh",   ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2);

    run_op("div_neg", ALU_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run_op("rem_neg", ALU_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run_op("divu",    ALU_DIVU, 32'd100,      32'd7, 32'd14,       34);
    run_op("remu",    ALU_REMU, 32'd100,      32'd7, 32'd2,        34);

    run_op("div_z",   ALU_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_z",   ALU_REM,  32'd5,        32'd0,        32'd5,        1);
    run_op("remu_z",  ALU_REMU, 32'd7,        32'd0,        32'd7,        1);
    run_op("div_ovf", ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("bad_op",  6'h3F,    32'd9,        32'd9,        32'd0,        1);

    // Back-to-back: new MUL accepted in the DONE cycle of a DIVU.
    @(negedge clk);
    start = 1'b1; alucode = ALU_DIVU; op1 = 32'd100; op2 = 32'd7;
    lat = 0; seen = 1'b0; gap = 0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) seen = 1'b1;
      else if (stall !== 1'b1) gap++;
    end
    chk("b2b_div_latency", lat, 34);
    chk("b2b_div_result", result, 32'd14);
    alucode = ALU_MUL; op1 = 32'd3; op2 = 32'd4;
    #1;
    chk("b2b_stall_in_done", stall, 1);
    @(posedge clk); #1;
    chk("b2b_mul_done_early", done, 0);
    chk("b2b_mul_stall", stall, 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_mul_done", done, 1);
    chk("b2b_mul_result", result, 32'd12);
    chk("b2b_stall_gaps", gap, 0);
    @(posedge clk); #1;

    // Flush ten cycles into a DIV.
    @(negedge clk);
    start = 1'b1; alucode = ALU_DIV; op1 = 32'hFFFFFFF9; op2 = 32'd2;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_busy_before", busy, 1);
    start = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_stall", stall, 0);
    chk("flush_result", result, 32'd12);
    flush = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("flush_no_done", saw_done, 0);
    run_op("post_flush_divu", ALU_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; alucode = ALU_DIV; op1 = 32'd1000; op2 = 32'd3;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_rst_busy", busy, 1);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_rem", ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
